// File: rtl/npc_bp_unit_if.sv
// Fetch- and execute-side signals of the next-PC / branch prediction unit.
// The pipeline is the master; npc_bp_unit is the slave.
interface npc_bp_unit_if #(
    parameter int XLEN = 32
);
    // Fetch side
    logic            stall;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    // Execute-side resolution
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      ex_op;
    logic            ex_br;
    logic [XLEN-1:0] ex_offset;
    logic [XLEN-1:0] ex_aluc;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output stall,
        output ex_valid, ex_pc, ex_op, ex_br, ex_offset, ex_aluc,
        output ex_pred_taken, ex_pred_target,
        input  pc, pc4, pred_taken, pred_target,
        input  redirect, redirect_pc
    );

    modport slave (
        input  stall,
        input  ex_valid, ex_pc, ex_op, ex_br, ex_offset, ex_aluc,
        input  ex_pred_taken, ex_pred_target,
        output pc, pc4, pred_taken, pred_target,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/npc_bp_unit.sv
// Fetch PC register with a direct-mapped BTB of 2-bit counters; predicts the
// next PC each cycle and redirects fetch when execute resolves a mispredict.
module npc_bp_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    npc_bp_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef enum logic [1:0] {
        NPC_OP_PC4  = 2'd0,
        NPC_OP_B    = 2'd1,
        NPC_OP_JAL  = 2'd2,
        NPC_OP_JALR = 2'd3
    } npc_op_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
        logic             is_jmp;
    } btb_entry_t;

    btb_entry_t             btb_mem [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc4;

    // Fetch-side lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    btb_entry_t       f_ent;
    logic             f_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    // Execute-side resolution
    npc_op_e          ex_op;
    logic             act_taken;
    logic [XLEN-1:0]  act_tgt;
    logic [XLEN-1:0]  rel_tgt;
    logic [XLEN-1:0]  seq_pc;
    logic             mispredict;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;

    // BTB update at the execute PC
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    btb_entry_t       e_ent;
    logic             e_hit;
    logic             upd_en;
    logic             wr_en;
    btb_entry_t       wr_ent;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    // ------------------------------------------------------------------
    // Lookup on the current fetch PC (sees pre-update BTB contents)
    // ------------------------------------------------------------------
    assign pc4         = pc_q + XLEN'(4);
    assign f_idx       = pc_q[IDX_W+1:2];
    assign f_tag       = pc_q[XLEN-1:IDX_W+2];
    assign f_ent       = btb_mem[f_idx];
    assign f_hit       = btb_valid[f_idx] && (f_ent.tag == f_tag);
    assign pred_taken  = f_hit && (f_ent.is_jmp || f_ent.ctr[1]);
    assign pred_target = f_hit ? f_ent.target : '0;

    // ------------------------------------------------------------------
    // Resolution of the instruction in execute
    // ------------------------------------------------------------------
    assign ex_op   = npc_op_e'(bus.ex_op);
    assign rel_tgt = bus.ex_pc + bus.ex_offset;
    assign seq_pc  = bus.ex_pc + XLEN'(4);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        act_taken = 1'b0;
        act_tgt   = rel_tgt;
        case (ex_op)
            NPC_OP_B:    act_taken = bus.ex_br;
            NPC_OP_JAL:  act_taken = 1'b1;
            NPC_OP_JALR: begin
                act_taken = 1'b1;
                act_tgt   = bus.ex_aluc & ~XLEN'(1);
            end
            default:     act_taken = 1'b0;
        endcase
    end

    assign mispredict  = (bus.ex_pred_taken != act_taken)
                       || (act_taken && (bus.ex_pred_target != act_tgt));
    assign redirect    = bus.ex_valid && !rst && mispredict;
    assign redirect_pc = act_taken ? act_tgt : seq_pc;

    // ------------------------------------------------------------------
    // BTB update: train on hit, allocate on taken miss, ignore plain ops
    // ------------------------------------------------------------------
    assign e_idx  = bus.ex_pc[IDX_W+1:2];
    assign e_tag  = bus.ex_pc[XLEN-1:IDX_W+2];
    assign e_ent  = btb_mem[e_idx];
    assign e_hit  = btb_valid[e_idx] && (e_ent.tag == e_tag);
    assign upd_en = bus.ex_valid && !rst && (ex_op != NPC_OP_PC4);

    always_comb begin
        wr_en  = 1'b0;
        wr_ent = e_ent;
        if (upd_en) begin
            if (e_hit) begin
                wr_en      = 1'b1;
                wr_ent.ctr = ctr_next(e_ent.ctr, act_taken);
                if (act_taken) begin
                    wr_ent.target = act_tgt;
                end
            end else if (act_taken) begin
                wr_en         = 1'b1;
                wr_ent.tag    = e_tag;
                wr_ent.target = act_tgt;
                wr_ent.ctr    = 2'b10;
                wr_ent.is_jmp = (ex_op != NPC_OP_B);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (wr_en) begin
            btb_valid[e_idx] <= 1'b1;
        end
    end

    // NOTE: the entry payload has no reset; the valid bits alone make stale
    // contents unobservable, which keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_mem[e_idx] <= wr_ent;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC register: reset > redirect > stall > prediction > pc+4
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
        end else if (!bus.stall) begin
            pc_q <= pred_taken ? pred_target : pc4;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;

endmodule
